// File: rtl/scp_int_pkg.sv
// rtl/scp_int_pkg.sv - shared constants and state encoding for the interrupt controller
package scp_int_pkg;

  localparam int          NUM_IRQ  = 8;
  localparam logic [15:0] VEC_BASE = 16'h0010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VECTOR = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_RETURN = 2'd3
  } int_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder over eight request bits
module irq_prio_enc
  import scp_int_pkg::*;
(
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = 3'd0;
    valid = |req;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - non-nesting vectored interrupt controller driving PC redirects
module int_ctrl #(
  parameter logic [15:0] VEC_BASE = scp_int_pkg::VEC_BASE,
  parameter int          NUM_IRQ  = scp_int_pkg::NUM_IRQ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               mask_we,
  input  logic               boundary,
  input  logic [15:0]        pc_val,
  input  logic               reti,
  output logic [15:0]        int_out,
  output logic               int_we,
  output logic               int_busy,
  output logic [2:0]         int_id,
  output logic [NUM_IRQ-1:0] pending
);

  import scp_int_pkg::*;

  int_state_e         state, state_nx;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] mask;
  logic [15:0]        saved_pc;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [2:0]         sel_idx;
  logic               sel_valid;
  logic               accept;

  assign irq_edge = irq & ~irq_q;
  assign clr_mask = accept ? (NUM_IRQ'(1) << sel_idx) : '0;
  assign int_busy = (state != ST_IDLE);

  irq_prio_enc u_prio (
    .req   (pending & ~mask),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // A new edge wins over the accept-time clear of the same line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q    <= '0;
      mask     <= '1;
      pending  <= '0;
      saved_pc <= 16'h0000;
      int_id   <= 3'd0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr_mask) | irq_edge;
      if (mask_we) mask <= mask_in;
      if (accept) begin
        saved_pc <= pc_val;
        int_id   <= sel_idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    int_we   = 1'b0;
    int_out  = 16'h0000;
    case (state)
      ST_IDLE: begin
        if (boundary && sel_valid) begin
          accept   = 1'b1;
          state_nx = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        int_we   = 1'b1;
        int_out  = VEC_BASE + {12'd0, int_id, 1'b0};
        state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (reti) state_nx = ST_RETURN;
      end
      ST_RETURN: begin
        int_we   = 1'b1;
        int_out  = saved_pc;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic [7:0]  mask_in;
  logic        mask_we;
  logic        boundary;
  logic [15:0] pc_val;
  logic        reti;
  logic [15:0] int_out;
  logic        int_we;
  logic        int_busy;
  logic [2:0]  int_id;
  logic [7:0]  pending;

  int errors = 0;
  int checks = 0;

  int_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .mask_in  (mask_in),
    .mask_we  (mask_we),
    .boundary (boundary),
    .pc_val   (pc_val),
    .reti     (reti),
    .int_out  (int_out),
    .int_we   (int_we),
    .int_busy (int_busy),
    .int_id   (int_id),
    .pending  (pending)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; irq = 8'h00; mask_in = 8'h00; mask_we = 1'b0;
    boundary = 1'b0; pc_val = 16'h0000; reti = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic unmask_all();
    mask_in = 8'h00; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (int_we !== 1'b0 || int_out !== 16'h0000 || int_busy !== 1'b0) begin
      errors++; $display("FAIL reset_outputs we=%b out=%h busy=%b want 0/0000/0", int_we, int_out, int_busy);
    end
    checks++;
    if (pending !== 8'h00 || int_id !== 3'd0) begin
      errors++; $display("FAIL reset_regs pending=%h id=%0d want 00/0", pending, int_id);
    end
  endtask

  task automatic test_single_and_return();
    unmask_all();
    irq = 8'h08; boundary = 1'b1; pc_val = 16'h1234;
    tick();
    checks++;
    if (pending !== 8'h08 || int_we !== 1'b0) begin
      errors++; $display("FAIL single_pend pending=%h we=%b want 08/0", pending, int_we);
    end
    tick();
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h0016 || int_id !== 3'd3 || pending !== 8'h00) begin
      errors++; $display("FAIL single_vector we=%b out=%h id=%0d pend=%h want 1/0016/3/00", int_we, int_out, int_id, pending);
    end
    boundary = 1'b0;
    tick();
    checks++;
    if (int_we !== 1'b0 || int_out !== 16'h0000 || int_busy !== 1'b1) begin
      errors++; $display("FAIL single_active we=%b out=%h busy=%b want 0/0000/1", int_we, int_out, int_busy);
    end
    reti = 1'b1;
    tick();
    reti = 1'b0;
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h1234) begin
      errors++; $display("FAIL return_pc we=%b out=%h want 1/1234", int_we, int_out);
    end
    tick();
    checks++;
    if (int_we !== 1'b0 || int_busy !== 1'b0) begin
      errors++; $display("FAIL return_idle we=%b busy=%b want 0/0", int_we, int_busy);
    end
    irq = 8'h00;
    tick();
  endtask

  task automatic test_priority();
    irq = 8'h22; boundary = 1'b1; pc_val = 16'h4000;
    tick();
    tick();
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h0012 || int_id !== 3'd1 || pending !== 8'h20) begin
      errors++; $display("FAIL prio_first we=%b out=%h id=%0d pend=%h want 1/0012/1/20", int_we, int_out, int_id, pending);
    end
    tick();
    tick();
    checks++;
    if (int_we !== 1'b0 || int_busy !== 1'b1 || pending !== 8'h20) begin
      errors++; $display("FAIL prio_no_nest we=%b busy=%b pend=%h want 0/1/20", int_we, int_busy, pending);
    end
    reti = 1'b1;
    tick();
    reti = 1'b0;
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h4000) begin
      errors++; $display("FAIL prio_return we=%b out=%h want 1/4000", int_we, int_out);
    end
    tick();
    tick();
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h001a || int_id !== 3'd5 || pending !== 8'h00) begin
      errors++; $display("FAIL prio_second we=%b out=%h id=%0d pend=%h want 1/001a/5/00", int_we, int_out, int_id, pending);
    end
    boundary = 1'b0; irq = 8'h00;
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    do_reset();
    irq = 8'h01; boundary = 1'b1;
    tick();
    tick();
    checks++;
    if (pending !== 8'h01 || int_we !== 1'b0 || int_busy !== 1'b0) begin
      errors++; $display("FAIL mask_hold pend=%h we=%b busy=%b want 01/0/0", pending, int_we, int_busy);
    end
    mask_in = 8'h00; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
    checks++;
    if (int_we !== 1'b0 || int_busy !== 1'b0) begin
      errors++; $display("FAIL mask_same_cycle we=%b busy=%b want 0/0", int_we, int_busy);
    end
    tick();
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h0010 || pending !== 8'h00) begin
      errors++; $display("FAIL mask_unmasked we=%b out=%h pend=%h want 1/0010/00", int_we, int_out, pending);
    end
    boundary = 1'b0; irq = 8'h00;
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
  endtask

  task automatic test_no_nesting();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    checks++;
    if (int_we !== 1'b0 || int_busy !== 1'b0 || pending !== 8'h00) begin
      errors++; $display("FAIL reti_idle we=%b busy=%b pend=%h want 0/0/00", int_we, int_busy, pending);
    end
    irq = 8'h10; boundary = 1'b1; pc_val = 16'h0abc;
    tick();
    tick();
    tick();
    irq = 8'h14;
    tick();
    tick();
    checks++;
    if (int_we !== 1'b0 || int_busy !== 1'b1 || pending !== 8'h04) begin
      errors++; $display("FAIL active_edge we=%b busy=%b pend=%h want 0/1/04", int_we, int_busy, pending);
    end
    reti = 1'b1;
    tick();
    reti = 1'b0;
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h0abc) begin
      errors++; $display("FAIL nest_return we=%b out=%h want 1/0abc", int_we, int_out);
    end
    tick();
    tick();
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h0014 || int_id !== 3'd2) begin
      errors++; $display("FAIL nest_after we=%b out=%h id=%0d want 1/0014/2", int_we, int_out, int_id);
    end
    boundary = 1'b0; irq = 8'h00;
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
  endtask

  task automatic test_set_wins();
    irq = 8'h40;
    tick();
    irq = 8'h00;
    tick();
    irq = 8'h40; boundary = 1'b1;
    tick();
    checks++;
    if (int_we !== 1'b1 || int_out !== 16'h001c || pending !== 8'h40) begin
      errors++; $display("FAIL set_wins we=%b out=%h pend=%h want 1/001c/40", int_we, int_out, pending);
    end
    boundary = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    checks++;
    if (int_busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_busy busy=%b want 1", int_busy);
    end
    do_reset();
    unmask_all();
    irq = 8'h02; boundary = 1'b1;
    tick();
    tick();
    checks++;
    if (int_we !== 1'b1 || int_id !== 3'd1) begin
      errors++; $display("FAIL pre_reset_vector we=%b id=%0d want 1/1", int_we, int_id);
    end
    irq = 8'h00;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (int_we !== 1'b0 || int_out !== 16'h0000 || int_busy !== 1'b0 || pending !== 8'h00) begin
      errors++; $display("FAIL reset_mid we=%b out=%h busy=%b pend=%h want 0/0000/0/00", int_we, int_out, int_busy, pending);
    end
    @(negedge clk);
    rst = 1'b1;
    irq = 8'h01; boundary = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (int_we !== 1'b0 || int_busy !== 1'b0 || pending !== 8'h01) begin
      errors++; $display("FAIL reset_mask we=%b busy=%b pend=%h want 0/0/01", int_we, int_busy, pending);
    end
  endtask

  initial begin
    rst = 1'b0; irq = 8'h00; mask_in = 8'h00; mask_we = 1'b0;
    boundary = 1'b0; pc_val = 16'h0000; reti = 1'b0;
    test_reset();
    test_single_and_return();
    test_priority();
    test_mask();
    test_no_nesting();
    test_set_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
